// File: rtl/permute_reg_file.sv
// Register file with an external write/read port and a small sequencer that
// permutes stored words (SWAP / COPY / ROT3 / NOP) through a single temp register.
module permute_reg_file #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] address_w,
    input  logic [DATA_WIDTH-1:0] data_w,
    input  logic [ADDR_WIDTH-1:0] address_r,
    output logic [DATA_WIDTH-1:0] data_r,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_code,
    input  logic [ADDR_WIDTH-1:0] address_A,
    input  logic [ADDR_WIDTH-1:0] address_B,
    input  logic [ADDR_WIDTH-1:0] address_C,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_drop
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_P1   = 3'd1;
    localparam logic [2:0] S_P2   = 3'd2;
    localparam logic [2:0] S_P3   = 3'd3;
    localparam logic [2:0] S_P4   = 3'd4;

    localparam logic [1:0] OP_SWAP = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_ROT3 = 2'b10;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [2:0]            state_q, state_d;
    logic [1:0]            opc_q, opc_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [ADDR_WIDTH-1:0] b_q, b_d;
    logic [ADDR_WIDTH-1:0] c_q, c_d;
    logic [DATA_WIDTH-1:0] tmp_q, tmp_d;
    logic                  done_q, done_d;
    logic                  wr_drop_q, wr_drop_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    assign op_ready = (state_q == S_IDLE);
    assign busy     = ~op_ready;
    assign done     = done_q;
    assign wr_drop  = wr_drop_q;
    assign data_r   = mem_q[address_r];

    // The single storage write port is shared: external writes in IDLE, op steps otherwise.
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        tmp_d     = tmp_q;
        done_d    = 1'b0;
        wr_drop_d = we && (state_q != S_IDLE);
        mem_we    = 1'b0;
        mem_wa    = address_w;
        mem_wd    = data_w;

        case (state_q)
            S_IDLE: begin
                mem_we = we;
                if (op_valid) begin
                    state_d = S_P1;
                    opc_d   = op_code;
                    a_d     = address_A;
                    b_d     = address_B;
                    c_d     = address_C;
                end
            end
            S_P1: begin
                case (opc_q)
                    OP_SWAP: begin
                        tmp_d   = mem_q[a_q];
                        state_d = S_P2;
                    end
                    OP_COPY: begin
                        mem_we  = 1'b1;
                        mem_wa  = b_q;
                        mem_wd  = mem_q[a_q];
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                    OP_ROT3: begin
                        tmp_d   = mem_q[c_q];
                        state_d = S_P2;
                    end
                    default: begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
            S_P2: begin
                mem_we  = 1'b1;
                mem_wd  = mem_q[b_q];
                mem_wa  = (opc_q == OP_ROT3) ? c_q : a_q;
                state_d = S_P3;
            end
            S_P3: begin
                mem_we  = 1'b1;
                mem_wa  = b_q;
                if (opc_q == OP_ROT3) begin
                    mem_wd  = mem_q[a_q];
                    state_d = S_P4;
                end else begin
                    mem_wd  = tmp_q;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_P4: begin
                mem_we  = 1'b1;
                mem_wa  = a_q;
                mem_wd  = tmp_q;
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            tmp_q     <= '0;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            tmp_q     <= tmp_d;
            done_q    <= done_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

endmodule

// File: tb/tb_permute_reg_file.sv
// Randomized bench for permute_reg_file against an array model that applies
// each operation atomically at acceptance.
module tb_permute_reg_file;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] address_w;
    logic [DW-1:0] data_w;
    logic [AW-1:0] address_r;
    logic [DW-1:0] data_r;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op_code;
    logic [AW-1:0] address_A;
    logic [AW-1:0] address_B;
    logic [AW-1:0] address_C;
    logic          busy;
    logic          done;
    logic          wr_drop;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] ref_mem [DEPTH];

    permute_reg_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .address_w (address_w),
        .data_w    (data_w),
        .address_r (address_r),
        .data_r    (data_r),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .address_A (address_A),
        .address_B (address_B),
        .address_C (address_C),
        .busy      (busy),
        .done      (done),
        .wr_drop   (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input logic [AW-1:0] a);
        @(negedge clk);
        address_r = a;
        #1;
        check($sformatf("mem[%0d]", a), 32'(data_r), 32'(ref_mem[a]));
    endtask

    function automatic int busy_len(input logic [1:0] code);
        case (code)
            2'd0:    return 3;
            2'd1:    return 1;
            2'd2:    return 4;
            default: return 1;
        endcase
    endfunction

    // Whole-operation effect, old-to-new in the documented step order.
    function automatic void model_op(input logic [1:0] code, input logic [AW-1:0] a,
                                     input logic [AW-1:0] b, input logic [AW-1:0] c);
        logic [DW-1:0] t;
        case (code)
            2'd0: begin t = ref_mem[a]; ref_mem[a] = ref_mem[b]; ref_mem[b] = t; end
            2'd1: ref_mem[b] = ref_mem[a];
            2'd2: begin
                t = ref_mem[c]; ref_mem[c] = ref_mem[b];
                ref_mem[b] = ref_mem[a]; ref_mem[a] = t;
            end
            default: ;
        endcase
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we        = 1'b1;
        address_w = a;
        data_w    = d;
        step();
        we = 1'b0;
        ref_mem[a] = d;
        check("wr_drop_idle", 32'(wr_drop), 0);
    endtask

    task automatic run_op(input logic [1:0] code, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] c, input bit ww, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input int drop_k);
        int n;
        op_valid  = 1'b1;
        op_code   = code;
        address_A = a;
        address_B = b;
        address_C = c;
        if (ww) begin
            we = 1'b1; address_w = wa; data_w = wd;
        end
        check("op_ready_pre", 32'(op_ready), 1);
        step();
        op_valid  = 1'b0;
        we        = 1'b0;
        op_code   = 2'($urandom);
        address_A = AW'($urandom);
        address_B = AW'($urandom);
        address_C = AW'($urandom);
        if (ww) ref_mem[wa] = wd;
        model_op(code, a, b, c);
        n = busy_len(code);
        for (int k = 0; k < n; k++) begin
            check("busy", 32'(busy), 1);
            check("op_ready_busy", 32'(op_ready), 0);
            check("done_early", 32'(done), 0);
            if (drop_k >= 0 && k == drop_k + 1) begin
                check("wr_drop_pulse", 32'(wr_drop), 1);
                we = 1'b0;
            end else begin
                check("wr_drop_quiet", 32'(wr_drop), 0);
            end
            if (k == drop_k) begin
                we = 1'b1; address_w = AW'($urandom); data_w = DW'($urandom);
            end
            step();
        end
        check("busy_end", 32'(busy), 0);
        check("done_pulse", 32'(done), 1);
        check("op_ready_end", 32'(op_ready), 1);
        if (drop_k == n - 1) check("wr_drop_pulse_end", 32'(wr_drop), 1);
        we = 1'b0;
        step();
        check("done_one_cycle", 32'(done), 0);
        check("wr_drop_clear", 32'(wr_drop), 0);
    endtask

    initial begin
        int busy_cnt;
        reset = 1'b1; we = 1'b0; op_valid = 1'b0; op_code = '0;
        address_w = '0; data_w = '0; address_r = 7'd5;
        address_A = '0; address_B = '0; address_C = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        #3;
        check("rst_op_ready", 32'(op_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_drop", 32'(wr_drop), 0);
        check("rst_data_r", 32'(data_r), 0);
        step();
        reset = 1'b0;
        #1;
        check("rel_op_ready", 32'(op_ready), 1);
        check("rel_data_r", 32'(data_r), 0);
        step();

        // SWAP 3<->9
        do_write(7'd3, 8'h11);
        do_write(7'd9, 8'h22);
        run_op(2'd0, 7'd3, 7'd9, 7'd0, 1'b0, '0, '0, -1);
        read_chk(7'd3);
        read_chk(7'd9);
        check("swap_a", 32'(ref_mem[3]), 32'h22);

        // ROT3 1,2,4
        do_write(7'd1, 8'hA1);
        do_write(7'd2, 8'hB2);
        do_write(7'd4, 8'hC4);
        run_op(2'd2, 7'd1, 7'd2, 7'd4, 1'b0, '0, '0, -1);
        read_chk(7'd1); read_chk(7'd2); read_chk(7'd4);

        // COPY with coincident external write on the source
        do_write(7'd5, 8'h5A);
        run_op(2'd1, 7'd5, 7'd6, 7'd0, 1'b1, 7'd5, 8'h77, -1);
        read_chk(7'd5); read_chk(7'd6);

        // Dropped write during SWAP
        do_write(7'd0, 8'h3C);
        do_write(7'd10, 8'h10);
        do_write(7'd11, 8'h20);
        run_op(2'd0, 7'd10, 7'd11, 7'd0, 1'b0, '0, '0, 0);
        read_chk(7'd0); read_chk(7'd10); read_chk(7'd11);

        // Back-to-back SWAP then COPY with op_valid held
        do_write(7'd20, 8'h01);
        do_write(7'd21, 8'h02);
        do_write(7'd22, 8'h03);
        do_write(7'd23, 8'h04);
        op_valid = 1'b1; op_code = 2'd0; address_A = 7'd20; address_B = 7'd21;
        step();
        model_op(2'd0, 7'd20, 7'd21, 7'd0);
        op_code = 2'd1; address_A = 7'd22; address_B = 7'd23;
        busy_cnt = 0;
        for (int s = 0; s < 6; s++) begin
            if (busy) busy_cnt++;
            if (s == 3) check("b2b_done1", 32'(done), 1);
            if (s == 4) begin
                check("b2b_copy_busy", 32'(busy), 1);
                op_valid = 1'b0;
            end
            if (s == 5) check("b2b_done2", 32'(done), 1);
            step();
        end
        check("b2b_busy_cycles", 32'(busy_cnt), 4);
        model_op(2'd1, 7'd22, 7'd23, 7'd0);
        read_chk(7'd20); read_chk(7'd21); read_chk(7'd23);

        // Reset during P2 of ROT3
        do_write(7'd30, 8'hAA);
        do_write(7'd31, 8'hBB);
        do_write(7'd32, 8'hCC);
        op_valid = 1'b1; op_code = 2'd2;
        address_A = 7'd30; address_B = 7'd31; address_C = 7'd32;
        step();
        op_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_op_ready", 32'(op_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        address_r = 7'd31;
        #1;
        check("mid_rst_data_r", 32'(data_r), 0);
        step();
        check("mid_rst_done2", 32'(done), 0);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        #1;
        check("post_rst_op_ready", 32'(op_ready), 1);
        check("post_rst_data_r", 32'(data_r), 0);
        for (int s = 0; s < 3; s++) begin
            step();
            check("post_rst_no_done", 32'(done), 0);
        end
        read_chk(7'd30); read_chk(7'd32);
        do_write(7'd40, 8'h4E);
        do_write(7'd41, 8'h4F);
        run_op(2'd0, 7'd40, 7'd41, 7'd0, 1'b0, '0, '0, -1);
        read_chk(7'd40); read_chk(7'd41);

        // Aliased operands
        do_write(7'd50, 8'h55);
        do_write(7'd51, 8'h66);
        run_op(2'd0, 7'd50, 7'd50, 7'd0, 1'b0, '0, '0, -1);
        run_op(2'd1, 7'd51, 7'd51, 7'd0, 1'b0, '0, '0, -1);
        run_op(2'd2, 7'd50, 7'd51, 7'd50, 1'b0, '0, '0, -1);
        read_chk(7'd50); read_chk(7'd51);

        // Randomized mix
        for (int it = 0; it < 60; it++) begin
            logic [AW-1:0] ra, rb, rc, rwa;
            logic [1:0]    rcode;
            bit            rww;
            int            rdrop, rn;
            if ($urandom_range(0, 1) == 1) begin
                ra = AW'($urandom_range(0, 7)); rb = AW'($urandom_range(0, 7));
                rc = AW'($urandom_range(0, 7)); rwa = AW'($urandom_range(0, 7));
            end else begin
                ra = AW'($urandom); rb = AW'($urandom); rc = AW'($urandom); rwa = AW'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                do_write(rwa, DW'($urandom));
            end else begin
                rcode = 2'($urandom);
                rww   = ($urandom_range(0, 3) == 0);
                rn    = busy_len(rcode);
                rdrop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rn - 1) : -1;
                run_op(rcode, ra, rb, rc, rww, rwa, DW'($urandom), rdrop);
                read_chk(ra); read_chk(rb); read_chk(rc);
            end
        end

        for (int i = 0; i < DEPTH; i++) read_chk(AW'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/permute_reg_file.md
PERMUTE_REG_FILE -- requirements
Module: permute_reg_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, register address width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each register.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports we  input  1, address_w  input  ADDR_WIDTH, and data_w  input  DATA_WIDTH: external write port.
REQ-006 SHALL have ports address_r  input  ADDR_WIDTH and data_r  output  DATA_WIDTH: external read port.
REQ-007 SHALL have ports op_valid  input  1, op_ready  output  1, and op_code  input  2: operation request handshake.
REQ-008 SHALL have ports address_A, address_B, address_C  input  ADDR_WIDTH each: operand addresses.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port wr_drop  output  1  one-cycle pulse when an external write is discarded.

Function
REQ-012 SHALL store 2**ADDR_WIDTH registers of DATA_WIDTH bits; data_r = mem[address_r] combinationally at all times, including while busy.
REQ-013 SHALL decode op_code as: 00 SWAP (A<->B), 01 COPY (B<=A), 10 ROT3 (A<=C, B<=A, C<=B, old values), 11 NOP.
REQ-014 SHALL use FSM states IDLE, P1, P2, P3, P4; op_ready = (state==IDLE); busy = !op_ready.
REQ-015 SHALL accept an op on the rising edge where op_valid & op_ready, latching op_code, address_A/B/C; IDLE->P1.
REQ-016 SHALL ignore op_code and address changes after acceptance until the op completes.
REQ-017 SHALL perform at most one storage read into an internal temp and one storage write per edge, in this order:
  - SWAP: P1 tmp<=mem[A]; P2 mem[A]<=mem[B]; P3 mem[B]<=tmp.
  - COPY: P1 mem[B]<=mem[A].
  - ROT3: P1 tmp<=mem[C]; P2 mem[C]<=mem[B]; P3 mem[B]<=mem[A]; P4 mem[A]<=tmp.
  - NOP: P1 no storage change.
REQ-018 SHALL return to IDLE on the edge performing the final action, and assert done for exactly the following cycle.
REQ-019 SHALL have busy cycle counts after acceptance of SWAP 3, COPY 1, ROT3 4, NOP 1.
REQ-020 SHALL permit a new op to be accepted in the same cycle that done is high; back-to-back ops SHALL have no idle gap.
REQ-021 SHALL perform an external write (we=1) at the edge only when state==IDLE.
REQ-022 SHALL, when we=1 coincides with op acceptance, commit the write at the acceptance edge so the op operates on the written value.
REQ-023 SHALL, when we=1 while busy, not modify storage and assert wr_drop for the following cycle.
REQ-024 SHALL not special-case aliased operands; results follow the REQ-017 action order.
  - SWAP with A==B: contents unchanged.
  - COPY with A==B: contents unchanged.
  - ROT3 with A==C: A and B unchanged.
REQ-025 SHALL wrap nothing: every address is in range by construction, so no bounds checking is required.

Reset
REQ-026 SHALL, on reset assertion and regardless of clock, clear all registers to 0, force IDLE, clear tmp, and deassert done, wr_drop, and busy.
REQ-027 SHALL, on reset mid-operation, discard the in-flight op with no further writes and no done pulse.
REQ-028 SHALL drive op_ready=1 and data_r=0 while reset is high and in the first cycle after release.

Verification
REQ-029 Write mem[3]=0x11, mem[9]=0x22; SWAP A=3 B=9 -> busy for 3 cycles, then done for 1 cycle; mem[3]=0x22, mem[9]=0x11.
REQ-030 mem[1]=0xA1, mem[2]=0xB2, mem[4]=0xC4; ROT3 A=1 B=2 C=4 -> after 4 busy cycles mem[1]=0xC4, mem[2]=0xA1, mem[4]=0xB2.
REQ-031 COPY A=5 B=6 with mem[5]=0x5A accepted at the same edge as we=1, address_w=5, data_w=0x77 -> mem[5]=mem[6]=0x77, done after 1 busy cycle.
REQ-032 During SWAP, we=1 address_w=0 data_w=0xFF -> mem[0] unchanged, wr_drop pulses 1 cycle, swap result correct.
REQ-033 Issue SWAP then COPY back-to-back with op_valid held high -> COPY accepted in the done cycle and 4 consecutive busy cycles total.
REQ-034 Assert reset in P2 of ROT3 -> all registers read 0, op_ready=1, done stays 0, next SWAP executes normally.
